// File: rtl/max_index_arbiter.sv
// max_index_arbiter
// Pipelined N-input maximum-value arbiter. Returns the index of the eligible
// input holding the largest unsigned value; ties go to the lowest index.
// One tournament level per pipeline stage, valid/ready on both sides.
//
// Parameters:
//   N      number of inputs (>= 2, need not be a power of two)
//   W      width of each unsigned input value
//   IDX_W  index width, derived from N (leave at default)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input vector valid
//   in_ready   block accepts a vector this cycle (= not stalled)
//   in_data    entry i at in_data[i*W +: W]
//   in_en      per-entry eligibility
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_idx    winning index (0 when out_none)
//   out_none   no entry was eligible
//   out_value  winning value (0 when out_none), only with ARB_VALUE_OUT_EN
//
// Build option: define ARB_VALUE_OUT_EN to add the out_value port.

module max_index_arbiter #(
    parameter int N     = 16,
    parameter int W     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_none
`ifdef ARB_VALUE_OUT_EN
    ,
    output logic [W-1:0]     out_value
`endif
);

    localparam int          L = IDX_W;
    localparam int unsigned P = 1 << L;

    typedef struct packed {
        logic             en;
        logic [W-1:0]     val;
        logic [IDX_W-1:0] idx;
    } cand_t;

    // Tree in heap order: node j has children 2j (lower indices) and 2j+1.
    // Nodes P..2P-1 are the leaves (input i is node P+i), node 1 is the root.
    // Registered internal nodes live in node_q[2..P-1]; the root is stored
    // directly in the output registers.
    cand_t       leaf   [P];
    cand_t       node_q [P];
    logic [L:1]  vld_q;
    logic        stall;

    logic             root_en;
    logic [IDX_W-1:0] root_idx;
`ifdef ARB_VALUE_OUT_EN
    logic [W-1:0]     root_val;
`endif

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_q[L];

    function automatic cand_t pick(input cand_t l, input cand_t r);
        cand_t w;
        w    = (r.en && (!l.en || (r.val > l.val))) ? r : l;
        w.en = l.en | r.en;
        return w;
    endfunction

    function automatic cand_t child(input int unsigned j);
        return (j >= P) ? leaf[j - P] : node_q[j];
    endfunction

    // Valid bit feeding stage s (stage 1 is fed by the input port).
    function automatic logic src_vld(input int unsigned s);
        return (s == 1) ? in_valid : vld_q[s - 1];
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < P; i++) begin
            leaf[i]     = '0;
            leaf[i].idx = IDX_W'(i);
            if (i < N) begin
                leaf[i].en  = in_en[i];
                leaf[i].val = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        cand_t w;
        w        = pick(child(2), child(3));
        root_en  = w.en;
        root_idx = w.idx;
`ifdef ARB_VALUE_OUT_EN
        root_val = w.val;
`endif
    end

    // Stage s = L - depth. Each stage only loads when its source is valid, so
    // input data is sampled solely on a transfer and bubbles leave data as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            for (int unsigned j = 0; j < P; j++) begin
                node_q[j] <= '0;
            end
            out_idx  <= '0;
            out_none <= 1'b0;
`ifdef ARB_VALUE_OUT_EN
            out_value <= '0;
`endif
        end else if (!stall) begin
            vld_q[1] <= in_valid;
            for (int unsigned s = 2; s <= L; s++) begin
                vld_q[s] <= vld_q[s - 1];
            end
            for (int unsigned d = 1; d < L; d++) begin
                if (src_vld(L - d)) begin
                    for (int unsigned j = (1 << d); j < (2 << d); j++) begin
                        node_q[j] <= pick(child(2 * j), child(2 * j + 1));
                    end
                end
            end
            if (src_vld(L)) begin
                out_none <= ~root_en;
                out_idx  <= root_en ? root_idx : '0;
`ifdef ARB_VALUE_OUT_EN
                out_value <= root_en ? root_val : '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_max_index_arbiter.sv
// Testbench for max_index_arbiter: three instances (N=4, N=9, N=16), a
// reference model feeding per-instance scoreboards, and directed scenarios
// for ties, masking, back-pressure, bubbles and mid-stream reset.

module tb_max_index_arbiter;

    localparam int NU = 3;

    typedef struct {
        int idx;
        int none;
        int val;
        int cnt;
        bit lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv  [NU];
    logic         ir  [NU];
    logic         ov  [NU];
    logic         orr [NU];
    logic         on  [NU];
    logic [127:0] id  [NU];
    logic [15:0]  ie  [NU];
    logic [7:0]   ovl [NU];
    logic [1:0]   idx4;
    logic [3:0]   idx9;
    logic [3:0]   idx16;

    exp_t sb [NU][$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   ncyc = 0;
    bit   lat_chk = 1'b1;
    int   pops [NU];
    bit   prev_stall [NU];
    int   prev_idx [NU];
    int   prev_none [NU];
    int   prev_val [NU];

    always #5 clk = ~clk;

    max_index_arbiter #(.N(4), .W(8)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0][31:0]), .in_en(ie[0][3:0]),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .out_idx(idx4), .out_none(on[0])
`ifdef ARB_VALUE_OUT_EN
        , .out_value(ovl[0])
`endif
    );

    max_index_arbiter #(.N(9), .W(8)) u9 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1][71:0]), .in_en(ie[1][8:0]),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .out_idx(idx9), .out_none(on[1])
`ifdef ARB_VALUE_OUT_EN
        , .out_value(ovl[1])
`endif
    );

    max_index_arbiter #(.N(16), .W(8)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .in_en(ie[2]),
        .out_valid(ov[2]), .out_ready(orr[2]),
        .out_idx(idx16), .out_none(on[2])
`ifdef ARB_VALUE_OUT_EN
        , .out_value(ovl[2])
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int n_of(input int u);
        return (u == 0) ? 4 : (u == 1) ? 9 : 16;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : 4;
    endfunction

    function automatic int get_idx(input int u);
        return (u == 0) ? int'(idx4) : (u == 1) ? int'(idx9) : int'(idx16);
    endfunction

    function automatic int get_val(input int u);
`ifdef ARB_VALUE_OUT_EN
        return int'(ovl[u]);
`else
        return (u < 0) ? 1 : 0;
`endif
    endfunction

    // Linear scan reference: first strictly larger eligible value wins.
    function automatic exp_t model(input int u, input logic [127:0] d, input logic [15:0] en);
        exp_t       e;
        int         best;
        logic [7:0] bv;
        best = -1;
        bv   = '0;
        for (int i = 0; i < n_of(u); i++) begin
            if (en[i] && (best < 0 || d[i*8 +: 8] > bv)) begin
                best = i;
                bv   = d[i*8 +: 8];
            end
        end
        e.none = (best < 0) ? 1 : 0;
        e.idx  = (best < 0) ? 0 : best;
        e.val  = (best < 0) ? 0 : int'(bv);
        e.cnt  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    // Monitor: inputs and outputs are stable at the falling edge, so a
    // handshake seen here is the transfer taken at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst_n) begin
                for (int u = 0; u < NU; u++) begin
                    int   gi;
                    exp_t e;
                    gi = get_idx(u);
                    if (prev_stall[u]) begin
                        check("stall_hold_valid", ov[u], 1);
                        check("stall_hold_idx", gi, prev_idx[u]);
                        check("stall_hold_none", on[u], prev_none[u]);
                        check("stall_hold_value", get_val(u), prev_val[u]);
                    end
                    check("in_ready", ir[u], (ov[u] && !orr[u]) ? 0 : 1);
                    if (ov[u] && orr[u]) begin
                        if (sb[u].size() == 0) begin
                            check("unexpected_out", 1, 0);
                        end else begin
                            e = sb[u].pop_front();
                            pops[u]++;
                            check("idx", gi, e.idx);
                            check("none", on[u], e.none);
`ifdef ARB_VALUE_OUT_EN
                            check("value", get_val(u), e.val);
`endif
                            if (e.lat) check("latency", ncyc - e.cnt, lat_of(u));
                        end
                    end
                    if (iv[u] && ir[u]) begin
                        e     = model(u, id[u], ie[u]);
                        e.cnt = ncyc;
                        e.lat = lat_chk;
                        sb[u].push_back(e);
                    end
                    prev_stall[u] = ov[u] && !orr[u];
                    prev_idx[u]   = gi;
                    prev_none[u]  = on[u];
                    prev_val[u]   = get_val(u);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send(input int u, input logic [127:0] d, input logic [15:0] en);
        int g;
        iv[u] = 1'b1;
        id[u] = d;
        ie[u] = en;
        g = 0;
        @(negedge clk);
        while (!ir[u] && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        iv[u] = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 40) check("drain_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_vec();
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'($urandom_range(0, 3) * 64 + $urandom_range(0, 1));
        return d;
    endfunction

    initial begin
        logic [127:0] d;
        int           p0;
        int           q;
        int           g;

        rst_n = 1'b0;
        for (int u = 0; u < NU; u++) begin
            iv[u] = 1'b0; orr[u] = 1'b1; id[u] = '0; ie[u] = '0;
            pops[u] = 0; prev_stall[u] = 1'b0;
        end
        #2;
        for (int u = 0; u < NU; u++) begin
            check("rst_valid", ov[u], 0);
            check("rst_idx", get_idx(u), 0);
            check("rst_none", on[u], 0);
            check("rst_in_ready", ir[u], 1);
            check("rst_value", get_val(u), 0);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // basic max, N=4
        d = '0; d[31:0] = 32'h1080_7F05;
        send(0, d, 16'hF);
        // ties, N=4
        d[31:0] = 32'h3333_3333;
        send(0, d, 16'hF);
        send(0, d, 16'hC);
        drain();

        // masking, N=9
        d = '0;
        for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'(i + 1);
        d[3*8 +: 8] = 8'h40;
        d[8*8 +: 8] = 8'hFF;
        send(1, d, 16'h00FF);
        send(1, d, 16'h0000);
        send(1, d, 16'h01FF);
        drain();

        // bubbles, N=16: valid pattern 1,0,1
        p0 = pops[2];
        send(2, rand_vec(), 16'hFFFF);
        @(posedge clk);
        #1;
        d = '0;
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'hAA;
        send(2, d, 16'hC000);
        drain();
        check("bubble_pulses", pops[2] - p0, 2);

        // back-pressure, N=4
        p0 = pops[0];
        orr[0] = 1'b0;
        lat_chk = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    d = '0;
                    d[31:0] = {8'(k * 3), 8'(k), 8'(16 - k), 8'(k * 7)};
                    send(0, d, 16'hF);
                end
            end
            begin
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!ov[0] && g < 100);
                check("bp_first_valid", ov[0], 1);
                check("bp_in_ready_drop", ir[0], 0);
                repeat (3) @(posedge clk);
                #1;
                orr[0] = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;
        check("bp_result_count", pops[0] - p0, 5);

        // random traffic with random back-pressure, N=4 and N=16
        lat_chk = 1'b0;
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    send(0, rand_vec(), ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom));
                end
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    orr[0] = 1'($urandom_range(0, 1));
                end
                orr[0] = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;
        for (int k = 0; k < 8; k++) send(2, rand_vec(), ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom));
        drain();

        // reset with two vectors in flight, N=4
        d = '0; d[31:0] = 32'h0102_0304;
        send(0, d, 16'hF);
        send(0, d, 16'h3);
        check("rst_mid_valid_before", ov[0], 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", ov[0], 0);
        check("rst_mid_idx", get_idx(0), 0);
        for (int u = 0; u < NU; u++) begin
            sb[u].delete();
            prev_stall[u] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov[0]) q++;
        end
        check("rst_mid_quiet", q, 0);
        @(posedge clk);
        #1;
        d[31:0] = 32'h9000_0090;
        send(0, d, 16'hF);
        drain();

        for (int u = 0; u < NU; u++) check("sb_empty", sb[u].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/max_index_arbiter.md
# max_index_arbiter

Pipelined N-input maximum-value arbiter. It returns the index of the eligible input with the largest unsigned value, with ties going to the lowest index. Each tournament level is registered, and the block uses a valid/ready handshake on both sides. It is the scalable successor to the 4-input combinational priority arbiter and serves the move-selection path, where board-cell scores (9 or more cells) are ranked every cycle.

## Interface
- N, 16: number of inputs, N ≥ 2; need not be a power of 2.
- W, 8: width of each input value (unsigned).
- IDX_W, $clog2(N): width of the index output (derived; do not override).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low. One clock domain only; reset is asynchronous and active-low.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_data  input  N*W  entry i at in_data[i*W +: W].
- in_en  input  N  per-entry eligibility; 0 means the entry can never win.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_idx  output  IDX_W  winning index.
- out_none  output  1  no entry was eligible (in_en all zero).

## Operation
- Inputs are padded to P = 2^clog2(N) entries. Pad entries are ineligible with value 0.
- The tournament tree has L = clog2(P) levels. Level k reduces P/2^k candidates to P/2^(k+1).
- Each candidate carries {eligible, value, index}.
- Node rule, with left always the lower index:
  - If right is eligible AND (left is ineligible OR right.value > left.value), the right candidate wins.
  - Otherwise the left candidate wins, so ties go to the lower index.
  - The winner's eligible bit is (left.eligible OR right.eligible).
- Value comparison is unsigned, full W bits, strict greater-than.
- Each level's output is registered together with a per-stage valid bit.
- Final stage outputs:
  - out_idx = winner index.
  - out_none = NOT winner.eligible.
  - When out_none = 1, out_idx = 0.
- A transfer occurs on a cycle with valid AND ready high at the respective port.

## Timing
- Reset (async assert, sync release): all stage valid bits = 0, out_valid = 0, out_idx = 0, out_none = 0. in_ready = 1 when out_valid = 0 after reset.
- Latency: exactly L cycles from input transfer to out_valid with no stall. Examples: N=2 gives L=1, N=4 gives L=2, N=9 or 16 gives L=4.
- Throughput: one vector per cycle.
- Stall: stall = out_valid AND NOT out_ready.
  - The whole pipeline holds and every stage register keeps its value.
  - in_ready = NOT stall (combinational). No bubble collapsing.
- During a stall, out_valid, out_idx and out_none stay stable until the transfer completes.
- If in_valid = 1 while in_ready = 0, the vector is not captured. The source must hold it.
- Bubbles (in_valid = 0 on a non-stalled cycle) propagate as invalid stages and never produce out_valid.
- Simultaneous output accept and input capture in the same cycle is legal. The pipeline advances by one.
- Reset mid-operation: all in-flight vectors are discarded. No partial result is emitted.
- in_data and in_en are sampled only on an input transfer cycle.

## Configuration
- ARB_VALUE_OUT_EN defined:
  - Adds output port out_value [W-1:0], carrying the winning value through the pipeline.
  - out_value = 0 when out_none = 1 and at reset.
  - It stalls together with out_idx.
- ARB_VALUE_OUT_EN undefined:
  - The port is absent.
  - Value bits are dropped at the final stage, so no output value register is built.
  - Index and handshake behaviour is identical.

## Test plan
- N=4, W=8, in_data = {in3=0x10, in2=0x80, in1=0x7F, in0=0x05}, in_en = 4'hF, out_ready = 1 -> out_valid exactly 2 cycles after transfer, out_idx = 2, out_none = 0.
- Ties, N=4: all values 0x33, in_en = 4'hF -> out_idx = 0. Same vector with in_en = 4'b1100 -> out_idx = 2.
- Masking, N=9: cell 8 = 0xFF with in_en[8] = 0, cell 3 = 0x40 the largest eligible value -> out_idx = 3. With in_en = 0 -> out_none = 1, out_idx = 0 (out_value = 0 when ARB_VALUE_OUT_EN is defined).
- Back-pressure, N=4: stream 5 vectors back-to-back while holding out_ready = 0 for 3 cycles after the first out_valid.
  - in_ready drops in the same cycle out_valid rises.
  - Outputs stay stable during the stall.
  - All 5 results arrive in order, with none lost or duplicated.
- Reset mid-stream: assert rst_n = 0 asynchronously while 2 vectors are in flight -> out_valid = 0 immediately. No result appears after release until a new input transfer plus L cycles.
- Bubbles, N=16: in_valid pattern 1,0,1 -> exactly two out_valid pulses, 2 cycles apart, first one at cycle 4.
